my_if_rx_sink: RTL

//   Receiving end of the my_if valid/ready byte channel (AccessOut side).
//   - Samples data/valid from an initiator and drives ready.
//   - Buffers accepted bytes in a first-word-fall-through FIFO that the

---
 rtl/my_if_rx_sink_if.sv | 11 +
 rtl/my_if_rx_sink.sv | 119 +++++++++++
 2 files changed

// File: rtl/my_if_rx_sink_if.sv
// my_if valid/ready byte channel: the initiator drives data/valid, the receiver drives ready.
interface my_if_rx_sink_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] vif_data;
  logic              vif_valid;
  logic              vif_ready;

  modport master (output vif_data, output vif_valid, input vif_ready);
  modport slave  (input vif_data, input vif_valid, output vif_ready);
endinterface

// File: rtl/my_if_rx_sink.sv
// Receiving end of the my_if channel: FWFT FIFO, accepted-transfer counter and an optional
// handshake checker that is built only when MY_IF_RX_PROTO_CHECK_EN is defined.
module my_if_rx_sink #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  my_if_rx_sink_if.slave          vif,
  input  logic                    pop,
  output logic [DATA_W-1:0]       pop_data,
  output logic                    pop_valid,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        rx_count,
  output logic                    proto_err,
  input  logic                    clear_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  rx_count_q, rx_count_d;
  logic              ready;
  logic              accept;
  logic              pop_fire;

  // Ready comes purely from the registered level, so a pop on a full FIFO frees
  // the slot only for the following cycle.
  assign ready     = (level_q != LVL_W'(DEPTH));
  assign accept    = vif.vif_valid && ready;
  assign pop_fire  = pop && (level_q != '0);

  assign vif.vif_ready = ready;
  assign pop_valid     = (level_q != '0);
  assign pop_data      = mem_q[rd_ptr_q];
  assign level         = level_q;
  assign rx_count      = rx_count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rx_count_d = rx_count_q;
    if (accept) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      rx_count_d = rx_count_q + CNT_W'(1);
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (accept && !pop_fire) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_fire && !accept) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rx_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rx_count_q <= rx_count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= vif.vif_data;
    end
  end

`ifdef MY_IF_RX_PROTO_CHECK_EN
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] stall_data_q, stall_data_d;
  logic              proto_err_q, proto_err_d;
  logic              violation;

  always_comb begin
    violation    = stall_q && (!vif.vif_valid || (vif.vif_data != stall_data_q));
    stall_d      = vif.vif_valid && !ready;
    stall_data_d = vif.vif_data;
    proto_err_d  = proto_err_q;
    if (violation) begin
      proto_err_d = 1'b1;
    end else if (clear_err) begin
      proto_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q      <= 1'b0;
      stall_data_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      stall_q      <= stall_d;
      stall_data_q <= stall_data_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  logic unused_clear_err;
  assign unused_clear_err = clear_err;
  assign proto_err        = 1'b0;
`endif
endmodule
